// File: rtl/ruleid_rd_arb.sv
// Read-port arbiter for the rule ID table: lookups have priority, status reads are routed back by tag.
// Optional status-read aging is enabled by defining RULEID_ARB_AGING_EN.
module ruleid_rd_arb #(
    parameter int AWIDTH  = 13,
    parameter int DWIDTH  = 32,
    parameter int RD_LAT  = 2,
    parameter int AGE_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lk_valid,
    input  logic [AWIDTH-1:0] lk_addr,
    output logic              lk_ready,
    output logic              lk_rsp_valid,
    output logic [DWIDTH-1:0] lk_rsp_data,
    input  logic              st_valid,
    input  logic [AWIDTH-1:0] st_addr,
    output logic              st_ready,
    output logic              st_rsp_valid,
    output logic [DWIDTH-1:0] st_rsp_data,
    output logic              mem_rden,
    output logic [AWIDTH-1:0] mem_rdaddress,
    input  logic [DWIDTH-1:0] mem_q,
    output logic [31:0]       lk_cnt,
    output logic [31:0]       st_cnt
);

    localparam int AGE_W = $clog2(AGE_MAX + 1);

    logic force_st;
    logic lk_hs;
    logic st_hs;

    // Ready logic never looks at st_valid, so lk_ready has no path from the status side.
    assign lk_ready = !force_st;
    assign st_ready = !lk_valid || force_st;
    assign lk_hs    = lk_valid && lk_ready;
    assign st_hs    = st_valid && st_ready && !lk_hs;

`ifdef RULEID_ARB_AGING_EN
    logic [AGE_W-1:0] age;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age <= '0;
        end else if (!st_valid || st_hs) begin
            age <= '0;
        end else if (age != AGE_W'(AGE_MAX)) begin
            age <= age + AGE_W'(1);
        end
    end

    assign force_st = (age == AGE_W'(AGE_MAX));
`else
    assign force_st = 1'b0;
`endif

    // Tag stage k is valid in the (k+1)th cycle after the grant; the last stage lines up with mem_q.
    logic [RD_LAT:0] tag_v;
    logic [RD_LAT:0] tag_st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v         <= '0;
            tag_st        <= '0;
            mem_rdaddress <= '0;
        end else begin
            tag_v  <= {tag_v[RD_LAT-1:0], lk_hs || st_hs};
            tag_st <= {tag_st[RD_LAT-1:0], st_hs};
            if (lk_hs) begin
                mem_rdaddress <= lk_addr;
            end else if (st_hs) begin
                mem_rdaddress <= st_addr;
            end
        end
    end

    assign mem_rden = tag_v[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_rsp_valid <= 1'b0;
            st_rsp_valid <= 1'b0;
            lk_rsp_data  <= '0;
            st_rsp_data  <= '0;
        end else begin
            lk_rsp_valid <= tag_v[RD_LAT] && !tag_st[RD_LAT];
            st_rsp_valid <= tag_v[RD_LAT] && tag_st[RD_LAT];
            if (tag_v[RD_LAT] && !tag_st[RD_LAT]) begin
                lk_rsp_data <= mem_q;
            end
            if (tag_v[RD_LAT] && tag_st[RD_LAT]) begin
                st_rsp_data <= mem_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_cnt <= '0;
            st_cnt <= '0;
        end else begin
            if (lk_hs) begin
                lk_cnt <= lk_cnt + 32'd1;
            end
            if (st_hs) begin
                st_cnt <= st_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ruleid_rd_arb.sv
// Scoreboard bench for ruleid_rd_arb: stimulus pushes expected responses, a monitor pops and compares.
module tb_ruleid_rd_arb;

    localparam int AW      = 13;
    localparam int DW      = 32;
    localparam int RD_LAT  = 2;
    localparam int AGE_MAX = 16;
    localparam int LAT     = RD_LAT + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          lk_valid = 1'b0;
    logic [AW-1:0] lk_addr = '0;
    logic          lk_ready;
    logic          lk_rsp_valid;
    logic [DW-1:0] lk_rsp_data;
    logic          st_valid = 1'b0;
    logic [AW-1:0] st_addr = '0;
    logic          st_ready;
    logic          st_rsp_valid;
    logic [DW-1:0] st_rsp_data;
    logic          mem_rden;
    logic [AW-1:0] mem_rdaddress;
    logic [DW-1:0] mem_q;
    logic [31:0]   lk_cnt;
    logic [31:0]   st_cnt;

    ruleid_rd_arb #(.AWIDTH(AW), .DWIDTH(DW), .RD_LAT(RD_LAT), .AGE_MAX(AGE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_ready(lk_ready),
        .lk_rsp_valid(lk_rsp_valid), .lk_rsp_data(lk_rsp_data),
        .st_valid(st_valid), .st_addr(st_addr), .st_ready(st_ready),
        .st_rsp_valid(st_rsp_valid), .st_rsp_data(st_rsp_data),
        .mem_rden(mem_rden), .mem_rdaddress(mem_rdaddress), .mem_q(mem_q),
        .lk_cnt(lk_cnt), .st_cnt(st_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: data = addr + 0x1000, valid RD_LAT cycles after mem_rden
    logic [DW-1:0] mpipe [RD_LAT];
    always @(posedge clk) begin
        mpipe[0] <= mem_rden ? (32'(mem_rdaddress) + 32'h1000) : 32'hDEAD_BEEF;
        for (int i = 1; i < RD_LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mem_q = mpipe[RD_LAT-1];

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t lk_q[$];
    exp_t st_q[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (lk_rsp_valid) begin
                if (lk_q.size() == 0) chk("lk_unexpected_rsp", 64'(lk_rsp_valid), 64'd0);
                else begin
                    e = lk_q.pop_front();
                    chk("lk_rsp_data", 64'(lk_rsp_data), 64'(e.data));
                    chk("lk_rsp_cycle", 64'(cyc), 64'(e.due));
                end
            end
            if (st_rsp_valid) begin
                if (st_q.size() == 0) chk("st_unexpected_rsp", 64'(st_rsp_valid), 64'd0);
                else begin
                    e = st_q.pop_front();
                    chk("st_rsp_data", 64'(st_rsp_data), 64'(e.data));
                    chk("st_rsp_cycle", 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    task automatic step(bit lv, logic [AW-1:0] la, bit sv, logic [AW-1:0] sa, bit exp_lr, bit exp_sr);
        exp_t e;
        @(negedge clk);
        lk_valid = lv; lk_addr = la; st_valid = sv; st_addr = sa;
        #1;
        chk("lk_ready", 64'(lk_ready), 64'(exp_lr));
        chk("st_ready", 64'(st_ready), 64'(exp_sr));
        if (lv && exp_lr) begin
            e.data = 32'(la) + 32'h1000; e.due = cyc + LAT; lk_q.push_back(e);
        end else if (sv && exp_sr) begin
            e.data = 32'(sa) + 32'h1000; e.due = cyc + LAT; st_q.push_back(e);
        end
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; lk_valid = 1'b0; st_valid = 1'b0;
        lk_q.delete(); st_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit lr;
        bit sr;
        bit sv;
        // reset values under random inputs
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            lk_valid = 1'($urandom_range(0, 1)); st_valid = 1'($urandom_range(0, 1));
            lk_addr = AW'($urandom); st_addr = AW'($urandom);
            #1;
            chk("rst_mem_rden", 64'(mem_rden), 64'd0);
            chk("rst_mem_addr", 64'(mem_rdaddress), 64'd0);
            chk("rst_lk_rsp_valid", 64'(lk_rsp_valid), 64'd0);
            chk("rst_st_rsp_valid", 64'(st_rsp_valid), 64'd0);
            chk("rst_lk_rsp_data", 64'(lk_rsp_data), 64'd0);
            chk("rst_st_rsp_data", 64'(st_rsp_data), 64'd0);
            chk("rst_lk_cnt", 64'(lk_cnt), 64'd0);
            chk("rst_st_cnt", 64'(st_cnt), 64'd0);
            chk("rst_lk_ready", 64'(lk_ready), 64'd1);
            chk("rst_st_ready", 64'(st_ready), 64'(!lk_valid));
        end
        @(negedge clk);
        lk_valid = 1'b0; st_valid = 1'b0; rst_n = 1'b1;
        step(1'b1, 13'h005, 1'b0, '0, 1'b1, 1'b0);
        idle(6);

        // interleave lookup then status
        do_reset();
        step(1'b1, 13'h010, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 13'h020, 1'b1, 1'b1);
        idle(6);
        chk("ilv_lk_cnt", 64'(lk_cnt), 64'd1);
        chk("ilv_st_cnt", 64'(st_cnt), 64'd1);

        // contention: continuous lookups, status pending from cycle 0
        do_reset();
        for (int k = 0; k < 40; k++) begin
`ifdef RULEID_ARB_AGING_EN
            lr = (k != AGE_MAX); sr = (k == AGE_MAX); sv = (k <= AGE_MAX);
`else
            lr = 1'b1; sr = 1'b0; sv = 1'b1;
`endif
            step(1'b1, AW'(13'h100 + k), sv, 13'h0AA, lr, sr);
        end
        idle(6);
`ifdef RULEID_ARB_AGING_EN
        chk("cont_st_cnt", 64'(st_cnt), 64'd1);
        chk("cont_lk_cnt", 64'(lk_cnt), 64'd39);
`else
        chk("cont_st_cnt", 64'(st_cnt), 64'd0);
        chk("cont_lk_cnt", 64'(lk_cnt), 64'd40);
`endif

        // throughput: 100 back-to-back lookups
        do_reset();
        for (int i = 0; i < 100; i++) step(1'b1, AW'(i), 1'b0, '0, 1'b1, 1'b0);
        idle(6);
        chk("tput_lk_cnt", 64'(lk_cnt), 64'd100);
        chk("tput_lk_q_empty", 64'(lk_q.size()), 64'd0);

        // reset mid-flight: three grants then reset
        do_reset();
        for (int i = 1; i <= 3; i++) step(1'b1, AW'(i), 1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        lk_valid = 1'b0; rst_n = 1'b0;
        lk_q.delete(); st_q.delete();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            #1;
            chk("mid_lk_rsp_valid", 64'(lk_rsp_valid), 64'd0);
            chk("mid_st_rsp_valid", 64'(st_rsp_valid), 64'd0);
            chk("mid_lk_cnt", 64'(lk_cnt), 64'd0);
        end

        // counter wrap
        do_reset();
        @(negedge clk);
        force dut.lk_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.lk_cnt;
        step(1'b1, 13'h007, 1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        lk_valid = 1'b0;
        #1;
        chk("wrap_lk_cnt", 64'(lk_cnt), 64'd0);
        idle(6);

        chk("final_lk_q_empty", 64'(lk_q.size()), 64'd0);
        chk("final_st_q_empty", 64'(st_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ruleid_rd_arb.md
# ruleid_rd_arb

Read-port arbiter for the rule ID table BRAM. It shares the single table read port between two requesters: the datapath lookup stream, which is high priority and never stalls upstream, and the status-bus reader, which is low priority. It returns each read result to the requester that issued it. It sits directly in front of the `bram_dc_diff_width` read side, in the same clock domain as that read port.

## Interface
Parameters:
- `AWIDTH`, 13: table read address width.
- `DWIDTH`, 32: table read data width.
- `RD_LAT`, 2: BRAM read latency in cycles, from `mem_rden` to valid `mem_q`; minimum 1.
- `AGE_MAX`, 16: starvation threshold for status reads, in cycles; minimum 1.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `lk_valid`  in  1  lookup request.
- `lk_addr`  in  AWIDTH  lookup address.
- `lk_ready`  out  1  lookup accepted this cycle (combinational).
- `lk_rsp_valid`  out  1  lookup response strobe.
- `lk_rsp_data`  out  DWIDTH  lookup response data.
- `st_valid`  in  1  status read request.
- `st_addr`  in  AWIDTH  status read address.
- `st_ready`  out  1  status request accepted (combinational).
- `st_rsp_valid`  out  1  status response strobe.
- `st_rsp_data`  out  DWIDTH  status response data.
- `mem_rden`  out  1  BRAM read enable (registered).
- `mem_rdaddress`  out  AWIDTH  BRAM read address (registered).
- `mem_q`  in  DWIDTH  BRAM read data.
- `lk_cnt`  out  32  count of accepted lookups; wraps.
- `st_cnt`  out  32  count of accepted status reads; wraps.

## Operation
- Grant rules:
  - At most one grant per cycle.
  - `force_st` = (age == `AGE_MAX`).
  - `lk_ready` = !`force_st`.
  - `st_ready` = !`lk_valid` || `force_st`.
  - A handshake is valid && ready.
- Issue: on a handshake, the next cycle drives `mem_rden`=1 with the granted address. With no handshake, `mem_rden`=0 and `mem_rdaddress` holds its last value.
- Owner tracking:
  - A tag shift register of depth `RD_LAT`+1 carries {valid, owner} alongside each read.
  - When a tag reaches the end, `mem_q` is registered into the owner's `*_rsp_data`, and that owner's `*_rsp_valid` pulses for 1 cycle.
  - The other requester's `*_rsp_data` holds its value.
- Responses have no backpressure. Both requesters must accept any response strobe.
- Age counter, width clog2(`AGE_MAX`+1):
  - Increments, saturating at `AGE_MAX`, each cycle that `st_valid` && !`st_ready`.
  - Clears to 0 on a status handshake or when `st_valid` is 0.
- Counters: `lk_cnt` / `st_cnt` increment by 1 on their handshake and wrap from 2^32-1 to 0.
- Boundary conditions:
  - Simultaneous requests with age < `AGE_MAX`: lookup wins.
  - Simultaneous requests with age == `AGE_MAX`: status wins and lookup waits exactly 1 cycle.
  - Back-to-back grants: full throughput of 1 read/cycle; tags never collide.
  - Reset mid-operation: in-flight tags are discarded, no response is emitted, and counters and age are cleared.
- Reset value of every output:
  - 0: `mem_rden`, `mem_rdaddress`, `*_rsp_valid`, `*_rsp_data`, `lk_cnt`, `st_cnt`.
  - `lk_ready`=1; `st_ready`=1 when `lk_valid`=0.

## Timing
- Handshake in cycle T, then:
  - `mem_rden` high in T+1.
  - `mem_q` sampled at the end of T+1+`RD_LAT`.
  - `*_rsp_valid` high in T+2+`RD_LAT`.
- Default end-to-end latency is 4 cycles.
- Response order equals grant order.
- Ready paths are combinational from `lk_valid` and the age register only; there is no path from `st_valid` to `lk_ready`.

## Configuration
- Macro: `RULEID_ARB_AGING_EN`.
- Defined: the age counter and `force_st` are present as described. A waiting status read is granted within `AGE_MAX`+1 cycles under any lookup load.
- Undefined:
  - The age counter is not instantiated and `force_st`=0.
  - Strict lookup priority applies, so `lk_ready`=1 always.
  - A status read can starve indefinitely under continuous `lk_valid`.

## Test plan
- Reset: hold `rst_n`=0 with random inputs. All reset values hold; after release, a single lookup to addr 0x005 with `mem_q` model = addr+0x1000 gives `lk_rsp_valid` at T+4 with `lk_rsp_data`=0x1005.
- Interleave: alternate a lookup at 0x010 and a status read at 0x020 when idle. Responses 0x1010 then 0x1020 route to the correct ports, 1 cycle apart; `lk_cnt`=1, `st_cnt`=1.
- Contention: `lk_valid` continuous for 40 cycles, `st_valid` raised at cycle 0.
  - With `RULEID_ARB_AGING_EN`: `st_ready` first high at cycle 16 and `lk_ready` low in that cycle only.
  - Without the macro: `st_ready` stays 0 for all 40 cycles.
- Throughput: 100 back-to-back lookups at addr 0..99 produce 100 consecutive `lk_rsp_valid` cycles with data 0x1000..0x1063 and no gaps.
- Reset mid-flight: assert `rst_n`=0 one cycle after 3 grants. No `*_rsp_valid` appears afterward, and `lk_cnt` reads 0.
- Wrap: preload the counter to 0xFFFF_FFFF via force. One more lookup gives `lk_cnt`=0.
